key_step_gen: RTL and testbench
===============================

Name: key_step_gen

Overview:
Upstream front-end for the ALU operand/opcode input stage. Takes a raw board push-button and the 16 board switches, then produces three things:
- a single-cycle `step` pulse per debounced press;
- switch data captured on that pulse (`data`);
- a 2-bit `phase` index mirroring the downstream field sequence (A, B, OP, FLAG).

The downstream capture stage advances exactly once per `step`, and `data` is stable whenever it samples.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or release (>= 2)
CNT_W, 20, debounce/repeat counter width; must hold DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD
KEY_ACTIVE_LOW, 1, 1 = key_raw low means pressed; 0 = high means pressed
REPEAT_DELAY, 500000, cycles in HELD before first auto-repeat (used only with AUTOREPEAT_EN)
REPEAT_PERIOD, 100000, cycles between subsequent auto-repeats (used only with AUTOREPEAT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_raw  input  1  asynchronous push-button level
sw  input  16  asynchronous switch bank
step  output  1  one-cycle pulse per accepted press (registered)
data  output  16  switch value captured on the same edge that raises step; held until next step
phase  output  2  field index, incremented on each step, wraps 3->0
key_level  output  1  debounced pressed level: 1 in HELD/REL_CHK, else 0

Behaviour:
- Reset (async, rst=1): state=ARM, cnt=0, step=0, data=0, phase=0, key_level=0. Synchroniser flops load the "released" value.
- Synchronisers:
  - key_raw passes through a 2-flop synchroniser; polarity is normalised to `pressed` (key_s) per KEY_ACTIVE_LOW.
  - sw passes through a 2-flop synchroniser (sw_s). data is always loaded from sw_s.
- FSM (5 states), evaluated each rising clk:
  - ARM (post-reset): key_s pressed -> cnt=0. Released -> cnt++. When cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - A key held through reset never produces a step until it is released for DEBOUNCE_CYCLES.
  - IDLE: key_s pressed -> PRESS_CHK, cnt=0.
  - PRESS_CHK: key_s released -> IDLE, with no step (bounce rejected). Otherwise cnt++.
    - On cnt==DEBOUNCE_CYCLES-1 -> HELD, and on the same edge: step<=1, data<=sw_s, phase<=phase+1.
  - HELD: key_s released -> REL_CHK, cnt=0.
  - REL_CHK: key_s pressed -> HELD, with no step. Otherwise cnt++. On cnt==DEBOUNCE_CYCLES-1 -> IDLE.
- step is high for exactly one cycle. It is cleared on every edge where no new pulse is generated.
- Latency: key_raw stably pressed, first sampled at edge 1 -> step high after edge DEBOUNCE_CYCLES+3, low after edge DEBOUNCE_CYCLES+4. Release debounce is symmetric.
- phase and data change only on the edge that raises step. phase is a 2-bit modulo counter: 3+1=0.
- Press shorter than DEBOUNCE_CYCLES: no step, no data/phase change.
- Reset asserted mid-PRESS_CHK or mid-HELD: immediate return to reset values, then ARM.
- cnt never exceeds DEBOUNCE_CYCLES-1 in debounce states; no counter wrap occurs.

Optional Feature:
AUTOREPEAT_EN
- Defined: HELD runs a repeat counter from the entry into HELD.
  - After REPEAT_DELAY cycles, issue a step (data<=sw_s, phase++).
  - Then issue another step every REPEAT_PERIOD cycles while still HELD.
  - Leaving HELD clears the repeat counter. Every repeat pulse is also one cycle wide.
- Undefined: HELD produces no pulses. REPEAT_DELAY/REPEAT_PERIOD are unused and no repeat logic is synthesised.

Test Plan:
(Simulation parameters: DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1.)
- Reset, then key_raw=1 for 10 cycles -> ARM->IDLE after 4 cycles; step, data, phase all 0; key_level=0.
- sw=16'hA5C3, key_raw=0 held 20 cycles -> exactly one step, high after edge 7; data=16'hA5C3, phase=1, key_level=1.
- key_raw=0 for 2 cycles then 1 (bounce) -> no step; phase unchanged; state back to IDLE.
- Four clean presses with sw=1,2,3,4 -> four steps; phase sequence 1,2,3,0; data ends 16'h0004. Change sw while HELD -> data does not change.
- key_raw=0 across rst pulse, held 20 cycles after rst drops -> no step until release for 4 cycles then a new press.
- With AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, key held 40 cycles -> steps at press +0, +10, +15, +20, +25, +30 relative to HELD entry; none after release.

Source files
------------

// File: rtl/key_step_gen.sv
// key_step_gen: debounced push-button to single-cycle step pulse, with
// switch capture and a 2-bit field phase for the ALU operand input stage.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_raw    raw push-button level (asynchronous)
//   sw[15:0]   raw switch bank (asynchronous)
//   step       one-cycle pulse per accepted press (registered)
//   data[15:0] sw captured on the edge that raises step
//   phase[1:0] field index, increments on each step, wraps 3->0
//   key_level  debounced pressed level (HELD / REL_CHK)
//
// Optional feature macro: AUTOREPEAT_EN (auto-repeat steps while held).

module key_step_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 20,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_raw,
    input  logic [15:0] sw,
    output logic        step,
    output logic [15:0] data,
    output logic [1:0]  phase,
    output logic        key_level
);

    localparam logic KEY_REL_LVL = (KEY_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_param_err
        $error("key_step_gen: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              key_m, key_q;
    logic [15:0]       sw_m, sw_q;
    logic              key_s;

    // Synchronisers idle at the released level so reset never looks
    // like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m <= KEY_REL_LVL;
            key_q <= KEY_REL_LVL;
            sw_m  <= '0;
            sw_q  <= '0;
        end else begin
            key_m <= key_raw;
            key_q <= key_m;
            sw_m  <= sw;
            sw_q  <= sw_m;
        end
    end

    assign key_s = (key_q != KEY_REL_LVL);

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rcnt counts cycles in HELD; rfirst selects the initial delay
    // versus the steady repeat period.
    logic [CNT_W-1:0] rcnt;
    logic             rfirst;
    logic             rfire;

    assign rfire = (rcnt == (rfirst ? RD_LAST : RP_LAST));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARM;
            cnt       <= '0;
            step      <= 1'b0;
            data      <= '0;
            phase     <= '0;
            key_level <= 1'b0;
`ifdef AUTOREPEAT_EN
            rcnt      <= '0;
            rfirst    <= 1'b1;
`endif
        end else begin
            step <= 1'b0;
            unique case (state)
                ARM: begin
                    if (key_s) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE: begin
                    if (key_s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!key_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        key_level <= 1'b1;
                        step      <= 1'b1;
                        data      <= sw_q;
                        phase     <= phase + 2'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        state <= REL_CHK;
                        cnt   <= '0;
`ifdef AUTOREPEAT_EN
                        rcnt   <= '0;
                        rfirst <= 1'b1;
                    end else if (rfire) begin
                        rcnt   <= '0;
                        rfirst <= 1'b0;
                        step   <= 1'b1;
                        data   <= sw_q;
                        phase  <= phase + 2'd1;
                    end else begin
                        rcnt <= rcnt + CNT_ONE;
`endif
                    end
                end
                REL_CHK: begin
                    if (key_s) begin
                        state <= HELD;
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        key_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_key_step_gen.sv
// tb_key_step_gen: scoreboard bench for key_step_gen (DEBOUNCE_CYCLES=4,
// active-low key). Expected steps are queued at stimulus time.

module tb_key_step_gen;

    localparam int DB = 4;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  p;
        int          e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_raw = 1'b1;
    logic [15:0] sw = '0;
    logic        step;
    logic [15:0] data;
    logic [1:0]  phase;
    logic        key_level;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    logic [1:0]  exp_ph = '0;
    exp_t        q[$];
    logic        prev_step = 1'b0;

    key_step_gen #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(8),
        .KEY_ACTIVE_LOW(1),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_raw(key_raw),
        .sw(sw),
        .step(step),
        .data(data),
        .phase(phase),
        .key_level(key_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (step) begin
            chk("step_width", 32'(prev_step), 32'd0);
            if (q.size() == 0) begin
                chk("spurious_step", 32'(step), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(data), 32'(e.d));
                chk("sb_phase", 32'(phase), 32'(e.p));
                chk("sb_cycle", 32'(cyc), 32'(e.e));
            end
        end
        prev_step <= step;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_ph = '0;
    endtask

    task automatic press(input int hold, input logic [15:0] swv,
                         input bit exp_step, input bit chg);
        int t0;
        @(negedge clk);
        sw = swv;
        key_raw = 1'b0;
        t0 = cyc;
        if (exp_step) begin
            exp_ph = exp_ph + 2'd1;
            q.push_back('{swv, exp_ph, t0 + DB + 3});
        end
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (chg && i == DB + 6) sw = ~swv;
        end
        if (exp_step && hold >= DB + 4)
            chk("key_level_held", 32'(key_level), 32'd1);
        if (chg)
            chk("data_stable", 32'(data), 32'(swv));
        @(negedge clk);
        key_raw = 1'b1;
        repeat (12) @(negedge clk);
        chk("key_level_rel", 32'(key_level), 32'd0);
    endtask

    initial begin
        int t0;
        int offs[6] = '{0, 10, 15, 20, 25, 30};

        // reset state, ARM -> IDLE on released key
        repeat (2) @(negedge clk);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_level", 32'(key_level), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("arm_step", 32'(step), 32'd0);
        chk("arm_phase", 32'(phase), 32'd0);
        chk("arm_level", 32'(key_level), 32'd0);

        // clean press, then bounces and the debounce boundary
        press(20, 16'hA5C3, 1'b1, 1'b0);
        chk("after_press_data", 32'(data), 32'hA5C3);
        press(2, 16'h1111, 1'b0, 1'b0);
        press(DB, 16'h2222, 1'b0, 1'b0);
        chk("bounce_phase", 32'(phase), 32'd1);
        chk("bounce_data", 32'(data), 32'hA5C3);
        press(DB + 1, 16'h3333, 1'b1, 1'b0);

        // phase wrap with four clean presses; sw changes while held
        do_reset();
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 4; i++)
            press(16, 16'(i), 1'b1, 1'b1);
        chk("wrap_phase", 32'(phase), 32'd0);
        chk("wrap_data", 32'(data), 32'h0004);

        // async reset while HELD
        @(negedge clk);
        sw = 16'hBEEF;
        key_raw = 1'b0;
        t0 = cyc;
        exp_ph = exp_ph + 2'd1;
        q.push_back('{16'hBEEF, exp_ph, t0 + DB + 3});
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_phase", 32'(phase), 32'd0);
        chk("midrst_level", 32'(key_level), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_ph = '0;

        // key held through reset: no step until released and re-pressed
        repeat (20) @(negedge clk);
        chk("held_rst_phase", 32'(phase), 32'd0);
        chk("held_rst_level", 32'(key_level), 32'd0);
        key_raw = 1'b1;
        repeat (10) @(negedge clk);
        press(12, 16'h5A5A, 1'b1, 1'b0);
        chk("held_rst_after", 32'(phase), 32'd1);

`ifdef AUTOREPEAT_EN
        @(negedge clk);
        sw = 16'h1234;
        key_raw = 1'b0;
        t0 = cyc;
        foreach (offs[k]) begin
            exp_ph = exp_ph + 2'd1;
            q.push_back('{16'h1234, exp_ph, t0 + DB + 3 + offs[k]});
        end
        repeat (39) @(negedge clk);
        key_raw = 1'b1;
        repeat (30) @(negedge clk);
`else
        chk("no_repeat_cfg", 32'(offs[1]), 32'd10);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
